// File: rtl/ksa_pipelined_subtractor.sv
// Pipelined two's-complement subtractor on a Kogge-Stone prefix carry tree.
// diff = in1 + ~in2 + 1, with prefix levels grouped LVL_PER_STG per pipeline
// stage. Latency is 1 + ceil($clog2(WIDTH)/LVL_PER_STG) cycles. A stall
// freezes the whole pipe, and in_ready is the global advance enable.
// Optional feature macro: KSS_ADD_SUB_EN adds a `sub` port that selects
// add (sub=0) or subtract (sub=1) per operand pair.
module ksa_pipelined_subtractor #(
  parameter int WIDTH       = 16,
  parameter int LVL_PER_STG = 2
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef KSS_ADD_SUB_EN
  input  logic             sub,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             overflow
);

  localparam int NLVL = (WIDTH > 1) ? $clog2(WIDTH) : 0;
  localparam int LPS  = (LVL_PER_STG >= 1) ? LVL_PER_STG : 1;
  localparam int NSTG = (NLVL + LPS - 1) / LPS;

  if (WIDTH < 1) begin : g_bad_width
    $fatal(1, "ksa_pipelined_subtractor: WIDTH must be >= 1");
  end
  if (LVL_PER_STG < 1) begin : g_bad_lps
    $fatal(1, "ksa_pipelined_subtractor: LVL_PER_STG must be >= 1");
  end

  // Prefix-tree state carried between stages. p0 is the bitwise propagate
  // kept for the final sum XOR; the MSBs feed the overflow decision.
  typedef struct packed {
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] p0;
    logic             msb1;
    logic             msb2;
    logic             sub;
  } stg_t;

  typedef struct packed {
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             overflow;
  } res_t;

  // Bitwise generate/propagate. The carry-in (1 for subtract) is folded
  // into G[0] so the tree never needs a separate carry-in term.
  function automatic stg_t stage0(input logic [WIDTH-1:0] a,
                                  input logic [WIDTH-1:0] b,
                                  input logic             s);
    stg_t             r;
    logic [WIDTH-1:0] bx;
    bx      = s ? ~b : b;
    r.p     = a ^ bx;
    r.g     = a & bx;
    r.g[0]  = r.g[0] | (s & r.p[0]);
    r.p0    = r.p;
    r.msb1  = a[WIDTH-1];
    r.msb2  = b[WIDTH-1];
    r.sub   = s;
    return r;
  endfunction

  // Kogge-Stone levels lo..hi (inclusive). Level k combines span 2**(k-1).
  function automatic stg_t prefix_levels(input stg_t s, input int lo, input int hi);
    stg_t r;
    stg_t prev;
    int   d;
    r = s;
    for (int k = lo; k <= hi; k++) begin
      prev = r;
      d    = 1 << (k - 1);
      for (int j = 0; j < WIDTH; j++) begin
        if (j >= d) begin
          r.g[j] = prev.g[j] | (prev.g[j-d] & prev.p[j]);
          r.p[j] = prev.p[j] & prev.p[j-d];
        end
      end
    end
    return r;
  endfunction

  // Sum, carry/borrow and signed overflow from the completed tree.
  function automatic res_t finalize(input stg_t s);
    res_t             r;
    logic [WIDTH-1:0] carries;
    carries[0] = s.sub;
    for (int j = 1; j < WIDTH; j++) begin
      carries[j] = s.g[j-1];
    end
    r.diff     = s.p0 ^ carries;
    r.borrow   = s.sub ? ~s.g[WIDTH-1] : s.g[WIDTH-1];
    r.overflow = s.sub ? ((s.msb1 != s.msb2) && (r.diff[WIDTH-1] != s.msb1))
                       : ((s.msb1 == s.msb2) && (r.diff[WIDTH-1] != s.msb1));
    return r;
  endfunction

  logic sub_i;
`ifdef KSS_ADD_SUB_EN
  assign sub_i = sub;
`else
  assign sub_i = 1'b1;
`endif

  logic             adv;
  logic [NSTG:0]    vld_q;
  logic [NSTG:0]    vld_d;
  res_t             res_q;
  res_t             res_d;
  stg_t             stg_d [NSTG+1];

  assign adv       = ~vld_q[NSTG] | out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_q[NSTG];
  assign diff      = res_q.diff;
  assign borrow    = res_q.borrow;
  assign overflow  = res_q.overflow;

  assign stg_d[0] = stage0(in1, in2, sub_i);

  for (genvar s = 1; s <= NSTG; s++) begin : g_stg
    localparam int LO = (s - 1) * LPS + 1;
    localparam int HI = (s * LPS < NLVL) ? s * LPS : NLVL;
    stg_t stg_q;
    // Stage data register: held while the pipe is stalled, never reset.
    always_ff @(posedge clk) begin
      if (adv) stg_q <= stg_d[s-1];
    end
    assign stg_d[s] = prefix_levels(stg_q, LO, HI);
  end

  // Next-state of valid chain and output register: shift on advance, else hold.
  always_comb begin
    vld_d = vld_q;
    res_d = res_q;
    if (adv) begin
      vld_d[0] = in_valid;
      for (int s = 1; s <= NSTG; s++) begin
        vld_d[s] = vld_q[s-1];
      end
      res_d = finalize(stg_d[NSTG]);
    end
  end

  // Valid bits and output result: cleared by reset, discarding in-flight work.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      res_q <= '0;
    end else begin
      vld_q <= vld_d;
      res_q <= res_d;
    end
  end

endmodule

// File: tb/tb_ksa_pipelined_subtractor.sv
// Self-checking bench for ksa_pipelined_subtractor (WIDTH=16, LVL_PER_STG=2).
// Reference: plain arithmetic on widened operands plus a slot-queue model of
// a freeze-on-stall pipeline of depth L. Optional macro KSS_ADD_SUB_EN.
module tb_ksa_pipelined_subtractor;

  localparam int W    = 16;
  localparam int LPS  = 2;
  localparam int NLVL = $clog2(W);
  localparam int NSTG = (NLVL + LPS - 1) / LPS;
  localparam int L    = 1 + NSTG;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in1;
  logic [W-1:0] in2;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         borrow;
  logic         overflow;
`ifdef KSS_ADD_SUB_EN
  logic         sub;
  localparam bit HAS_SUB = 1'b1;
`else
  localparam bit HAS_SUB = 1'b0;
`endif

  ksa_pipelined_subtractor #(.WIDTH(W), .LVL_PER_STG(LPS)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
`ifdef KSS_ADD_SUB_EN
    .sub      (sub),
`endif
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in1      (in1),
    .in2      (in2),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .diff     (diff),
    .borrow   (borrow),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         v;
    logic [W-1:0] d;
    logic         b;
    logic         o;
  } slot_t;

  slot_t pipe [L];
  int    n_cmp = 0;
  int    n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic slot_t empty_slot();
    slot_t r;
    r.v = 1'b0;
    r.d = '0;
    r.b = 1'b0;
    r.o = 1'b0;
    return r;
  endfunction

  // Result of a op b from plain integer arithmetic.
  function automatic slot_t ref_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    slot_t      r;
    logic [W:0] wide;
    int         sa;
    int         sb;
    int         sr;
    wide = s ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
    sa   = int'($signed(a));
    sb   = int'($signed(b));
    sr   = s ? (sa - sb) : (sa + sb);
    r.v  = 1'b1;
    r.d  = wide[W-1:0];
    r.b  = wide[W];
    r.o  = (sr > (2 ** (W - 1)) - 1) || (sr < -(2 ** (W - 1)));
    return r;
  endfunction

  // One clock: drive, compare against the model, clock, update the model.
  task automatic step(input logic iv, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic s, input logic ordy, output logic acc);
    logic adv;
    in_valid  = iv;
    in1       = a;
    in2       = b;
    out_ready = ordy;
`ifdef KSS_ADD_SUB_EN
    sub       = s;
`endif
    #1;
    adv = !pipe[L-1].v || ordy;
    check("in_ready", 32'(in_ready), 32'(adv));
    check("out_valid", 32'(out_valid), 32'(pipe[L-1].v));
    if (pipe[L-1].v) begin
      check("diff", 32'(diff), 32'(pipe[L-1].d));
      check("borrow", 32'(borrow), 32'(pipe[L-1].b));
      check("overflow", 32'(overflow), 32'(pipe[L-1].o));
    end
    acc = iv && adv;
    @(posedge clk);
    if (adv) begin
      for (int i = L - 1; i > 0; i--) pipe[i] = pipe[i-1];
      pipe[0] = iv ? ref_op(a, b, s) : empty_slot();
    end
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_borrow", 32'(borrow), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < L; i++) pipe[i] = empty_slot();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Single isolated op with out_ready=1: latency and fixed expected result.
  task automatic run_one(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic s, input logic [W-1:0] ed, input logic eb, input logic eo);
    logic acc;
    int   lat;
    step(1'b1, a, b, s, 1'b1, acc);
    check({tag, "_accept"}, 32'(acc), 32'd1);
    lat = 1;
    while (out_valid !== 1'b1 && lat < 20) begin
      step(1'b0, '0, '0, 1'b1, 1'b1, acc);
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(L));
    check({tag, "_diff"}, 32'(diff), 32'(ed));
    check({tag, "_borrow"}, 32'(borrow), 32'(eb));
    check({tag, "_overflow"}, 32'(overflow), 32'(eo));
    step(1'b0, '0, '0, 1'b1, 1'b1, acc);
  endtask

  function automatic logic pipe_busy();
    logic r;
    r = 1'b0;
    for (int i = 0; i < L; i++) r = r | pipe[i].v;
    return r;
  endfunction

  function automatic logic [W-1:0] pick_operand();
    logic [W-1:0] v;
    case ($urandom_range(0, 7))
      0:       v = '0;
      1:       v = '1;
      2:       v = {1'b1, {(W-1){1'b0}}};
      3:       v = {1'b0, {(W-1){1'b1}}};
      default: v = W'($urandom);
    endcase
    return v;
  endfunction

  initial begin
    logic acc;
    int   idx;
    int   cyc;
    logic ordy;
    logic s;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in1       = '0;
    in2       = '0;
    out_ready = 1'b0;
`ifdef KSS_ADD_SUB_EN
    sub       = 1'b1;
`endif
    for (int i = 0; i < L; i++) pipe[i] = empty_slot();
    @(negedge clk);
    apply_reset();

    // Directed arithmetic cases
    run_one("t1", 16'h0005, 16'h0003, 1'b1, 16'h0002, 1'b0, 1'b0);
    run_one("t2a", 16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b1, 1'b0);
    run_one("t2b", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b0, 1'b1);
    run_one("t2c", 16'h7FFF, 16'hFFFF, 1'b1, 16'h8000, 1'b1, 1'b1);
    run_one("t2d", 16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b0, 1'b0);

    // Back-to-back stream with a 5-cycle downstream stall
    idx = 0;
    cyc = 0;
    while ((idx < 8 || pipe_busy()) && cyc < 60) begin
      ordy = !(cyc >= 3 && cyc < 8);
      step(idx < 8, W'(idx), 16'h0001, 1'b1, ordy, acc);
      if (acc) idx++;
      cyc++;
    end
    check("t3_sent", 32'(idx), 32'd8);
    check("t3_drained", 32'(pipe_busy()), 32'd0);

    // Reset with two operations in flight
    step(1'b1, 16'h0100, 16'h0001, 1'b1, 1'b1, acc);
    step(1'b1, 16'h0200, 16'h0002, 1'b1, 1'b1, acc);
    apply_reset();
    for (int i = 0; i < 2 * L; i++) step(1'b0, '0, '0, 1'b1, 1'b1, acc);

`ifdef KSS_ADD_SUB_EN
    run_one("t6_add", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_one("t6_addovf", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
`endif

    // Randomized traffic with random backpressure
    for (int i = 0; i < 3000; i++) begin
      s = HAS_SUB ? 1'($urandom_range(0, 1)) : 1'b1;
      step($urandom_range(0, 3) != 0, pick_operand(), pick_operand(), s,
           $urandom_range(0, 9) < 7, acc);
    end

    cyc = 0;
    while (pipe_busy() && cyc < 20) begin
      step(1'b0, '0, '0, 1'b1, 1'b1, acc);
      cyc++;
    end
    check("final_drained", 32'(pipe_busy()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
